// File: rtl/alu_acc_seq.sv
// Accumulator sequencer around an external combinational 4-bit ALU.
// Takes {op,b} commands, runs them against the accumulator and returns {y,flags} downstream.
module alu_acc_seq #(
    parameter logic [3:0] ACC_RST = 4'h0,
    parameter bit         CMP_WB  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_op,
    input  logic [3:0] in_b,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [3:0] alu_y,
    input  logic [5:0] alu_flags,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_y,
    output logic [5:0] out_flags,
    output logic [3:0] acc,
    output logic       ovf_sticky,
    input  logic       ovf_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] OP_CMP  = 4'b1110;
    localparam int         FLAG_VF = 3;

    state_t     state;
    logic [3:0] op_r;
    logic [3:0] b_r;
    logic       acc_keep;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // The source holds valid and its payload until then; out_valid never drops without a transfer.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign alu_a    = acc;
    assign alu_b    = b_r;
    assign alu_op   = op_r;
    assign acc_keep = (op_r == OP_CMP) && !CMP_WB;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= ACC_RST;
            op_r      <= 4'h0;
            b_r       <= 4'h0;
            out_y     <= 4'h0;
            out_flags <= 6'h00;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r  <= in_op;
                        b_r   <= in_b;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    out_y     <= alu_y;
                    out_flags <= alu_flags;
                    out_valid <= 1'b1;
                    if (!acc_keep) begin
                        acc <= alu_y;
                    end
                    state <= HOLD;
                end
                HOLD: begin
                    // Result and next command can both transfer on the same edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            op_r  <= in_op;
                            b_r   <= in_b;
                            state <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clear wins over a same-cycle overflow capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end else if (state == EXEC && alu_flags[FLAG_VF]) begin
            ovf_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Bench for alu_acc_seq: two instances (CMP_WB=0 and CMP_WB=1) driven in lockstep,
// each wired to a behavioural 4-bit ALU, with directed scenarios and a randomized run.
module tb_alu_acc_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic       ovf_clr;
    logic [3:0] in_op;
    logic [3:0] in_b;

    logic       in_ready0, out_valid0, ovf0;
    logic [3:0] alu_a0, alu_b0, alu_op0, alu_y0, out_y0, acc0;
    logic [5:0] alu_flags0, out_flags0;

    logic       in_ready1, out_valid1, ovf1;
    logic [3:0] alu_a1, alu_b1, alu_op1, alu_y1, out_y1, acc1;
    logic [5:0] alu_flags1, out_flags1;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] exp_q[$];
    logic [3:0] m_acc0, m_acc1;
    logic       m_ovf0, m_ovf1;

    // ALU reference: {y, cf, bf, vf, zf, sf, pf}; pf=1 means even parity of y.
    function automatic logic [9:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        logic [3:0] y;
        logic       cf, bf, vf;
        r = 5'd0; y = 4'd0; cf = 1'b0; bf = 1'b0; vf = 1'b0;
        case (op)
            4'h0: begin r = a + b; y = r[3:0]; cf = r[4]; vf = (a[3] == b[3]) && (y[3] != a[3]); end
            4'h1, 4'hE: begin
                r = {1'b0, a} - {1'b0, b}; y = r[3:0]; bf = r[4]; cf = !r[4];
                vf = (a[3] != b[3]) && (y[3] != a[3]);
            end
            4'h2: y = a & b;
            4'h3: y = a | b;
            4'h4: y = a ^ b;
            4'h5: y = ~a;
            4'h6: begin r = a + 5'd1; y = r[3:0]; cf = r[4]; vf = (a == 4'h7); end
            4'h7: begin r = {1'b0, a} - 5'd1; y = r[3:0]; bf = r[4]; vf = (a == 4'h8); end
            4'h8: begin y = {a[2:0], 1'b0}; cf = a[3]; end
            4'h9: begin y = {1'b0, a[3:1]}; cf = a[0]; end
            4'hA: y = {a[2:0], a[3]};
            4'hB: y = {a[0], a[3:1]};
            4'hC: y = a;
            4'hD: y = b;
            default: y = 4'h0;
        endcase
        return {y, cf, bf, vf, (y == 4'h0), y[3], ~^y};
    endfunction

    assign {alu_y0, alu_flags0} = alu_f(alu_op0, alu_a0, alu_b0);
    assign {alu_y1, alu_flags1} = alu_f(alu_op1, alu_a1, alu_b1);

    alu_acc_seq #(.ACC_RST(4'h0), .CMP_WB(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_op(in_op), .in_b(in_b), .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0),
        .alu_y(alu_y0), .alu_flags(alu_flags0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_y(out_y0), .out_flags(out_flags0), .acc(acc0), .ovf_sticky(ovf0), .ovf_clr(ovf_clr)
    );

    alu_acc_seq #(.ACC_RST(4'h0), .CMP_WB(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_op(in_op), .in_b(in_b), .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
        .alu_y(alu_y1), .alu_flags(alu_flags1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_y(out_y1), .out_flags(out_flags1), .acc(acc1), .ovf_sticky(ovf1), .ovf_clr(ovf_clr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0; in_op = 4'h0; in_b = 4'h0;
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_acc0 = 4'h0; m_acc1 = 4'h0; m_ovf0 = 1'b0; m_ovf1 = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver / model ----------------
    // One full transaction: present command, wait for result, stall `stall` cycles, consume it.
    task automatic do_cmd(input logic [3:0] op, input logic [3:0] b, input int stall,
                          output logic [3:0] y, output logic [5:0] f, output logic to);
        int n;
        to = 1'b0; in_op = op; in_b = b; in_valid = 1'b1; out_ready = 1'b0; n = 0;
        #1;
        while (in_ready0 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        if (in_ready0 !== 1'b1) to = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; n = 0;
        while (out_valid0 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        if (out_valid0 !== 1'b1) to = 1'b1;
        repeat (stall) begin @(posedge clk); #1; end
        y = out_y0; f = out_flags0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Expected result for dut0 goes to the queue; CMP leaves acc alone unless CMP_WB=1.
    task automatic model_push(input logic [3:0] op, input logic [3:0] b);
        logic [9:0] e0, e1;
        e0 = alu_f(op, m_acc0, b);
        e1 = alu_f(op, m_acc1, b);
        exp_q.push_back(e0);
        if (op != 4'hE) m_acc0 = e0[9:6];
        m_acc1 = e1[9:6];
        m_ovf0 = m_ovf0 | e0[3];
        m_ovf1 = m_ovf1 | e1[3];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        in_op = 4'hD; in_b = 4'h9; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({out_valid0, acc0} !== {1'b1, 4'h9}) begin n_err++; $display("FAIL pre_reset_hold got v=%b acc=%h exp v=1 acc=9", out_valid0, acc0); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (acc0 !== 4'h0) begin n_err++; $display("FAIL reset_acc got %h exp 0", acc0); end
        n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid0); end
        n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready0); end
        n_cmp++; if ({out_y0, out_flags0} !== 10'h000) begin n_err++; $display("FAIL reset_out_data got y=%h f=%b exp 0", out_y0, out_flags0); end
        n_cmp++; if ({ovf0, alu_op0, alu_b0} !== 9'h000) begin n_err++; $display("FAIL reset_regs got ovf=%b op=%h b=%h exp 0", ovf0, alu_op0, alu_b0); end
        n_cmp++; if ({out_valid1, in_ready1, out_y1, out_flags1, acc1} !== 16'h4000) begin n_err++; $display("FAIL reset_dut1 got v=%b r=%b y=%h f=%b acc=%h", out_valid1, in_ready1, out_y1, out_flags1, acc1); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [3:0] y; logic [5:0] f; logic to;
        do_cmd(4'hD, 4'h5, 0, y, f, to);
        n_cmp++; if (to || y !== 4'h5) begin n_err++; $display("FAIL pass_b_y got %h exp 5 (timeout=%b)", y, to); end
        n_cmp++; if ({alu_op0, alu_b0, alu_a0} !== 12'hD55) begin n_err++; $display("FAIL idle_alu_inputs got op=%h b=%h a=%h exp D 5 5", alu_op0, alu_b0, alu_a0); end
        do_cmd(4'h0, 4'h3, 1, y, f, to);
        n_cmp++; if (to || y !== 4'h8 || f !== 6'b001010) begin n_err++; $display("FAIL add_result got y=%h f=%b exp y=8 f=001010", y, f); end
        n_cmp++; if ({acc0, ovf0} !== {4'h8, 1'b1}) begin n_err++; $display("FAIL add_acc_ovf got acc=%h ovf=%b exp 8 1", acc0, ovf0); end
    endtask

    task automatic test_sub();
        logic [3:0] y; logic [5:0] f; logic to;
        do_cmd(4'h1, 4'h8, 2, y, f, to);
        n_cmp++; if (to || y !== 4'h0 || f !== 6'b100101) begin n_err++; $display("FAIL sub_result got y=%h f=%b exp y=0 f=100101", y, f); end
        n_cmp++; if ({acc0, acc1} !== 8'h00) begin n_err++; $display("FAIL sub_acc got %h/%h exp 0/0", acc0, acc1); end
    endtask

    task automatic test_cmp();
        logic [3:0] y; logic [5:0] f; logic to;
        do_cmd(4'hD, 4'h3, 0, y, f, to);
        do_cmd(4'hE, 4'h5, 0, y, f, to);
        n_cmp++; if (to || y !== 4'hE || f !== 6'b010010) begin n_err++; $display("FAIL cmp_result got y=%h f=%b exp y=E f=010010", y, f); end
        n_cmp++; if (acc0 !== 4'h3) begin n_err++; $display("FAIL cmp_no_wb_acc got %h exp 3", acc0); end
        n_cmp++; if (acc1 !== 4'hE) begin n_err++; $display("FAIL cmp_wb_acc got %h exp E", acc1); end
    endtask

    task automatic test_backpressure();
        in_op = 4'hD; in_b = 4'hA; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_op = 4'h0; in_b = 4'h1;
        @(posedge clk); #1;
        n_cmp++; if ({out_valid0, out_y0} !== {1'b1, 4'hA}) begin n_err++; $display("FAIL bp_first got v=%b y=%h exp 1 A", out_valid0, out_y0); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({in_ready0, out_valid0, out_y0, acc0} !== {1'b0, 1'b1, 4'hA, 4'hA}) begin
                n_err++; $display("FAIL bp_stall%0d got rdy=%b v=%b y=%h acc=%h exp 0 1 A A", i, in_ready0, out_valid0, out_y0, acc0);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL bp_bypass_ready got %b exp 1", in_ready0); end
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid0 !== 1'b0) begin n_err++; $display("FAIL bp_consumed got v=%b exp 0", out_valid0); end
        @(posedge clk); #1;
        n_cmp++; if ({out_valid0, out_y0, acc0, acc1} !== {1'b1, 4'hB, 4'hB, 4'hB}) begin n_err++; $display("FAIL bp_second got v=%b y=%h acc=%h/%h exp 1 B B/B", out_valid0, out_y0, acc0, acc1); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_ovf_clr();
        logic [3:0] y; logic [5:0] f; logic to;
        do_cmd(4'hD, 4'h7, 0, y, f, to);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", ovf0); end
        in_op = 4'h0; in_b = 4'h1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({out_valid0, out_flags0[3], ovf0} !== 3'b110) begin n_err++; $display("FAIL ovf_clr_priority got v=%b vf=%b ovf=%b exp 1 1 0", out_valid0, out_flags0[3], ovf0); end
        ovf_clr = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        do_cmd(4'hD, 4'h7, 0, y, f, to);
        do_cmd(4'h0, 4'h1, 0, y, f, to);
        n_cmp++; if (to || ovf0 !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b exp 1", ovf0); end
    endtask

    task automatic test_reset_exec();
        in_op = 4'hD; in_b = 4'h9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({out_valid0, acc0, acc1} !== 9'h000) begin n_err++; $display("FAIL rst_exec got v=%b acc=%h/%h exp 0 0/0", out_valid0, acc0, acc1); end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++; if ({out_valid0, acc0} !== 5'h00) begin n_err++; $display("FAIL rst_exec_after%0d got v=%b acc=%h exp 0 0", i, out_valid0, acc0); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] op, b;
        logic [9:0] e;
        int k, got, last;
        apply_reset();
        k = 0; got = 0; last = -1;
        out_ready = 1'b1;
        op = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
        model_push(op, b); in_op = op; in_b = b; in_valid = 1'b1; k = 1;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            @(posedge clk); #1;
            if (out_valid0 === 1'b1) begin
                e = exp_q.pop_front();
                got++;
                n_cmp++; if ({out_y0, out_flags0} !== e) begin n_err++; $display("FAIL b2b_result%0d got %h/%b exp %h/%b", got, out_y0, out_flags0, e[9:6], e[5:0]); end
                if (last >= 0) begin
                    n_cmp++; if (cyc - last !== 2) begin n_err++; $display("FAIL b2b_spacing got %0d exp 2", cyc - last); end
                end
                last = cyc;
                if (k < 8) begin
                    op = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
                    model_push(op, b); in_op = op; in_b = b; k++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        n_cmp++; if (got !== 8) begin n_err++; $display("FAIL b2b_count got %0d exp 8", got); end
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        n_cmp++; if ({acc0, acc1} !== {m_acc0, m_acc1}) begin n_err++; $display("FAIL b2b_acc got %h/%h exp %h/%h", acc0, acc1, m_acc0, m_acc1); end
    endtask

    task automatic test_random();
        logic [3:0] op, b, y;
        logic [5:0] f;
        logic [9:0] e;
        logic to;
        apply_reset();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                ovf_clr = 1'b1;
                @(posedge clk); #1;
                ovf_clr = 1'b0;
                m_ovf0 = 1'b0; m_ovf1 = 1'b0;
            end
            op = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
            model_push(op, b);
            do_cmd(op, b, $urandom_range(0, 3), y, f, to);
            e = exp_q.pop_front();
            n_cmp++; if (to || {y, f} !== e) begin n_err++; $display("FAIL rand%0d_result op=%h b=%h got %h/%b exp %h/%b to=%b", i, op, b, y, f, e[9:6], e[5:0], to); end
            n_cmp++; if ({acc0, acc1} !== {m_acc0, m_acc1}) begin n_err++; $display("FAIL rand%0d_acc got %h/%h exp %h/%h", i, acc0, acc1, m_acc0, m_acc1); end
            n_cmp++; if ({ovf0, ovf1} !== {m_ovf0, m_ovf1}) begin n_err++; $display("FAIL rand%0d_ovf got %b/%b exp %b/%b", i, ovf0, ovf1, m_ovf0, m_ovf1); end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        apply_reset();
        test_reset();
        test_add();
        test_sub();
        test_cmp();
        test_backpressure();
        test_ovf_clr();
        test_reset_exec();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
